// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared sync-read memory port between fetch (IF) and data (D).
// Ports: if_* fetch side, d_* data side, mem_* shared memory, d_run_cnt debug.
module mem_port_arbiter #(
  parameter int AWIDTH    = 14,
  parameter int DWIDTH    = 32,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DWIDTH-1:0] if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout,
  input  logic              mem_ready,
  output logic [3:0]        d_run_cnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_D_RUN);

  typedef enum logic [1:0] {
    R_NONE,
    R_IF,
    R_D
  } resp_t;

  resp_t      resp_q;
  resp_t      resp_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       gnt_if;
  logic       gnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= R_NONE;
      cnt_q  <= 4'd0;
    end else begin
      resp_q <= resp_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (rst_n && mem_ready) begin
      if (if_req && d_req) begin
        // D has priority until IF has waited MAX_D_RUN grants.
        if (cnt_q >= MAX_CNT) gnt_if = 1'b1;
        else                  gnt_d  = 1'b1;
      end else if (if_req) begin
        gnt_if = 1'b1;
      end else if (d_req) begin
        gnt_d = 1'b1;
      end
    end
  end

  always_comb begin
    resp_d = R_NONE;
    cnt_d  = cnt_q;
    unique case (1'b1)
      gnt_if:  resp_d = R_IF;
      gnt_d:   resp_d = (d_we == 4'd0) ? R_D : R_NONE;
      default: resp_d = R_NONE;
    endcase
    if (gnt_if || !if_req) begin
      cnt_d = 4'd0;
    end else if (gnt_d && cnt_q < MAX_CNT) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    if_ready = gnt_if;
    d_ready  = gnt_d;
    mem_en   = gnt_if | gnt_d;
    mem_we   = 4'd0;
    mem_addr = if_addr;
    mem_din  = '0;
    if (gnt_d) begin
      mem_we   = d_we;
      mem_addr = d_addr;
      mem_din  = d_wdata;
    end
  end

  assign if_rvalid = (resp_q == R_IF);
  assign d_rvalid  = (resp_q == R_D);
  assign if_rdata  = mem_dout;
  assign d_rdata   = mem_dout;
  assign d_run_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-writable sync-read memory.
// Vectors are applied 1ns after posedge and checked on the negedge.
module tb_mem_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic [3:0]    d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          mem_ready;
  logic [3:0]    d_run_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AWIDTH(AW),
    .DWIDTH(DW),
    .MAX_D_RUN(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_ready(if_ready),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ready(d_ready),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .mem_ready(mem_ready),
    .d_run_cnt(d_run_cnt)
  );

  logic [31:0] mem_arr [0:255];

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = {24'h5A5A5A, 8'(i)};
    mem_arr[16] = 32'hDEADBEEF;
    mem_arr[32] = 32'hCAFEF00D;
    mem_dout = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != 4'd0) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem_arr[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
      end else begin
        mem_dout <= mem_arr[mem_addr[7:0]];
      end
    end
  end

  typedef struct {
    logic          ifr;
    logic [AW-1:0] ifa;
    logic          dr;
    logic [3:0]    dwe;
    logic [AW-1:0] da;
    logic [31:0]   dwd;
    logic          mrdy;
    logic          e_ifrdy;
    logic          e_drdy;
    logic          e_en;
    logic [3:0]    e_we;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_din;
    logic          e_ifv;
    logic          e_dv;
    logic [31:0]   e_rdata;
    logic [3:0]    e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic ifr, logic [AW-1:0] ifa, logic dr, logic [3:0] dwe,
    logic [AW-1:0] da, logic [31:0] dwd, logic mrdy,
    logic ifrdy, logic drdy, logic en, logic [3:0] we,
    logic [AW-1:0] addr, logic [31:0] din, logic ifv, logic dv,
    logic [31:0] rdata, logic [3:0] cnt);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe;
    v.da = da; v.dwd = dwd; v.mrdy = mrdy;
    v.e_ifrdy = ifrdy; v.e_drdy = drdy; v.e_en = en; v.e_we = we;
    v.e_addr = addr; v.e_din = din; v.e_ifv = ifv; v.e_dv = dv;
    v.e_rdata = rdata; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_req    = v.ifr;
    if_addr   = v.ifa;
    d_req     = v.dr;
    d_we      = v.dwe;
    d_addr    = v.da;
    d_wdata   = v.dwd;
    mem_ready = v.mrdy;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 14'h010;
    d_req = 1'b1; d_we = 4'd0; d_addr = 14'h020; d_wdata = '0;
    mem_ready = 1'b1;

    // Idle / fetch / data read / store / partial write
    vecs.push_back(mk(0,'h005,0,0,'h000,0,1, 0,0,0,0,'h005,0,0,0,0,0));
    vecs.push_back(mk(1,'h010,0,0,'h000,0,1, 1,0,1,0,'h010,0,0,0,0,0));
    vecs.push_back(mk(0,'h010,1,0,'h020,'h11111111,1,
                      0,1,1,0,'h020,'h11111111,1,0,'hDEADBEEF,0));
    vecs.push_back(mk(0,'h010,1,'hF,'h030,'h12345678,1,
                      0,1,1,'hF,'h030,'h12345678,0,1,'hCAFEF00D,0));
    vecs.push_back(mk(0,'h010,1,0,'h030,0,1, 0,1,1,0,'h030,0,0,0,0,0));
    vecs.push_back(mk(0,'h010,1,'h3,'h030,'hAAAABBBB,1,
                      0,1,1,'h3,'h030,'hAAAABBBB,0,1,'h12345678,0));
    vecs.push_back(mk(0,'h010,1,0,'h030,0,1, 0,1,1,0,'h030,0,0,0,0,0));
    vecs.push_back(mk(0,'h007,0,0,'h030,0,1,
                      0,0,0,0,'h007,0,0,1,'h1234BBBB,0));
    // Contention: D,D,D,D,IF,D
    vecs.push_back(mk(1,'h040,1,0,'h041,0,1, 0,1,1,0,'h041,0,0,0,0,0));
    vecs.push_back(mk(1,'h040,1,0,'h041,0,1,
                      0,1,1,0,'h041,0,0,1,'h5A5A5A41,1));
    vecs.push_back(mk(1,'h040,1,0,'h041,0,1,
                      0,1,1,0,'h041,0,0,1,'h5A5A5A41,2));
    vecs.push_back(mk(1,'h040,1,0,'h041,0,1,
                      0,1,1,0,'h041,0,0,1,'h5A5A5A41,3));
    vecs.push_back(mk(1,'h040,1,0,'h041,0,1,
                      1,0,1,0,'h040,0,0,1,'h5A5A5A41,4));
    vecs.push_back(mk(1,'h040,1,0,'h041,0,1,
                      0,1,1,0,'h041,0,1,0,'h5A5A5A40,0));
    // mem_ready low for 3 cycles: no grant, count holds
    vecs.push_back(mk(1,'h040,1,0,'h041,0,0,
                      0,0,0,0,'h040,0,0,1,'h5A5A5A41,1));
    vecs.push_back(mk(1,'h040,1,0,'h041,0,0, 0,0,0,0,'h040,0,0,0,0,1));
    vecs.push_back(mk(1,'h040,1,0,'h041,0,0, 0,0,0,0,'h040,0,0,0,0,1));
    vecs.push_back(mk(1,'h040,1,0,'h041,0,1, 0,1,1,0,'h041,0,0,0,0,1));
    // IF drops before grant: silently dropped, count clears
    vecs.push_back(mk(0,'h040,1,0,'h041,0,1,
                      0,1,1,0,'h041,0,0,1,'h5A5A5A41,2));
    vecs.push_back(mk(0,'h040,0,0,'h041,0,1,
                      0,0,0,0,'h040,0,0,1,'h5A5A5A41,0));
    vecs.push_back(mk(0,'h040,0,0,'h041,0,1, 0,0,0,0,'h040,0,0,0,0,0));

    // Reset state with both requesting
    #2;
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_d_ready",  32'(d_ready), 0);
    chk("rst_mem_en",   32'(mem_en), 0);
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_cnt",      32'(d_run_cnt), 0);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_if_ready", i), 32'(if_ready), 32'(vecs[i].e_ifrdy));
      chk($sformatf("v%0d_d_ready", i), 32'(d_ready), 32'(vecs[i].e_drdy));
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_mem_din", i), mem_din, vecs[i].e_din);
      chk($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].e_ifv));
      chk($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid), 32'(vecs[i].e_dv));
      chk($sformatf("v%0d_cnt", i), 32'(d_run_cnt), 32'(vecs[i].e_cnt));
      if (vecs[i].e_ifv)
        chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_dv)
        chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_rdata);
    end

    // Build a nonzero run count, then reset right after an IF read grant
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 14'h010;
    d_req = 1'b1; d_we = 4'd0; d_addr = 14'h020; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_cnt", 32'(d_run_cnt), 2);
    d_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_if_ready", 32'(if_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_if_rvalid", 32'(if_rvalid), 0);
    chk("mid_rst_if_ready", 32'(if_ready), 0);
    chk("mid_rst_mem_en", 32'(mem_en), 0);
    chk("mid_rst_cnt", 32'(d_run_cnt), 0);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_if_rvalid", k), 32'(if_rvalid), 0);
      chk($sformatf("post_rst%0d_d_rvalid", k), 32'(d_rvalid), 0);
      chk($sformatf("post_rst%0d_cnt", k), 32'(d_run_cnt), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, synchronous-read memory (1-cycle read latency, byte-write mask) between two requesters: instruction fetch (IF) and the load/store data path (D).
- Sits between the core's fetch/memory stages and the shared BIOS/IMEM-DMEM port.
- Arbitrates each cycle, drives the memory port, and routes read data back with a valid strobe.
- Fixed data priority, with a starvation guard that forces a fetch grant after a bounded run of data grants.

Parameters:
AWIDTH, 14, word address width of the shared memory
DWIDTH, 32, data width (must be 32; byte mask is 4 bits)
MAX_D_RUN, 4, max consecutive D grants while IF is requesting before IF is forced (1..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request, held until if_ready
if_addr  input  AWIDTH  fetch word address
if_ready  output  1  fetch request accepted this cycle (combinational)
if_rvalid  output  1  if_rdata valid (cycle after acceptance)
if_rdata  output  DWIDTH  fetch read data
d_req  input  1  data request, held until d_ready
d_we  input  4  byte write mask; 0 = read
d_addr  input  AWIDTH  data word address
d_wdata  input  DWIDTH  store data
d_ready  output  1  data request accepted this cycle (combinational)
d_rvalid  output  1  d_rdata valid (cycle after read acceptance)
d_rdata  output  DWIDTH  load read data
mem_en  output  1  memory enable
mem_we  output  4  memory byte write enable
mem_addr  output  AWIDTH  memory address
mem_din  output  DWIDTH  memory write data
mem_dout  input  DWIDTH  memory read data (registered inside memory)
mem_ready  input  1  memory can accept an access this cycle
d_run_cnt  output  4  current consecutive-D-grant count while IF waits (debug)

Behaviour:
- Reset (rst_n=0, async): if_rvalid=0, d_rvalid=0, resp_owner=NONE, d_run_cnt=0. Combinational outputs follow from inputs with grant logic; if_ready=d_ready=0 and mem_en=0 while rst_n=0.
- Grant, evaluated combinationally each cycle, only when mem_ready=1. When mem_ready=0: no grant, mem_en=0, mem_we=0.
- Both requesting and d_run_cnt < MAX_D_RUN: grant D.
- Both requesting and d_run_cnt == MAX_D_RUN: grant IF.
- Single requester: grant it.
- Granted port: its ready=1 and mem_en=1. mem_addr/mem_din come from the granted port. mem_we=d_we only when D is granted, else 0.
- When idle (no grant), mem_addr holds the IF address and mem_din/mem_we are 0.
- d_run_cnt update:
  - D granted while if_req=1: increment (saturate at MAX_D_RUN).
  - IF granted: clear to 0.
  - if_req=0: clear to 0.
- Response tracking: register resp_owner in {NONE, IF, D}.
  - IF granted -> IF.
  - D granted with d_we==0 -> D.
  - Otherwise -> NONE; D writes produce no response.
- Read return, one cycle after grant:
  - resp_owner==IF: if_rvalid=1 for exactly one cycle.
  - resp_owner==D: d_rvalid=1 for exactly one cycle.
  - if_rdata and d_rdata are both wired to mem_dout; the consumer qualifies with its rvalid.
- Back-to-back: a new grant may occur in the same cycle a previous response is returned. Throughput is 1 access/cycle.
- Requester that deasserts req before being granted: dropped silently; no response is generated.
- Reset asserted mid-read: the pending response is discarded, and no rvalid is issued after rst_n deasserts.
- Partial write (e.g. d_we=4'b0011) is passed through unchanged; the arbiter does no byte alignment.

Test Plan:
- Fetch only: if_req=1, if_addr=0x010, mem returns 0xDEADBEEF -> if_ready=1 in cycle 0, if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 1, d_rvalid=0.
- Data read only: d_req=1, d_we=0, d_addr=0x020 -> d_ready=1, mem_we=0; next cycle d_rvalid=1, d_rdata=mem_dout.
- Contention: if_req=d_req=1 held for 6 cycles, MAX_D_RUN=4 -> grants D,D,D,D,IF,D; d_run_cnt 1,2,3,4,0,1.
- Store: d_we=4'b1111, d_wdata=0x12345678, addr 0x030 -> mem_we=4'b1111, mem_din=0x12345678; d_rvalid stays 0 next cycle.
- mem_ready=0 for 3 cycles with both requesting -> no ready, mem_en=0, d_run_cnt unchanged; grant resumes on mem_ready=1.
- Assert rst_n=0 in the cycle after an IF read grant -> if_rvalid=0 during and after reset; d_run_cnt=0.
